tmds_channel_enc: RTL
=====================

# tmds_channel_enc

Single-channel DVI/HDMI TMDS encoder: converts one 8-bit colour component plus DE and two control bits into a 10-bit DC-balanced TMDS symbol every pixel clock. Sits between the pixel/timing pipeline and the OSER10 10:1 serializer. Three instances are used, one each for blue, green and red. Blue carries {vsync, hsync} on c1/c0; green and red tie c1/c0 to 0. The block is a fixed 2-stage pipeline that tracks running disparity across the active video of each line.

## Interface
- RST_CODE, default 10'b1101010100: value of q_out while in reset (control symbol for c1c0=00).
- pxl_clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- d  in  8  colour component, sampled when de=1.
- de  in  1  data enable; 1 = active video, 0 = control period.
- c0  in  1  control bit 0 (hsync on blue channel), used when de=0.
- c1  in  1  control bit 1 (vsync on blue channel), used when de=0.
- q_out  out  10  TMDS symbol; bit 0 is serialized first (feeds OSER10 D0..D9).
- disparity  out  5  signed two's-complement running disparity; for debug and verification.

## Operation
- Stage 1 (registered): capture d, de, c1, c0; compute n1 = popcount(d).
  - q_m[0] = d[0].
  - If n1>4, or (n1==4 and d[0]==0): q_m[i] = q_m[i-1] XNOR d[i] for i=1..7, q_m[8]=0.
  - Otherwise: q_m[i] = q_m[i-1] XOR d[i], q_m[8]=1.
  - Register q_m[8:0] with the delayed de/c1/c0.
- Stage 2 (registered): n1q = popcount(q_m[7:0]), n0q = 8-n1q. cnt is the 5-bit signed disparity register.
- When de=1, one of three cases applies:
  - Case A, cnt==0 or n1q==n0q:
    - q_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
  - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - q_out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0q-n1q).
  - Case C, otherwise:
    - q_out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (n1q-n0q).
- When de=0: cnt <= 0, and q_out is selected by {c1,c0}, written [9:0]:
  - 00 → 1101010100.
  - 01 → 0010101011.
  - 10 → 0101010100.
  - 11 → 1010101011.
- Arithmetic:
  - Evaluate all cnt math in signed 5 bits; |cnt| never exceeds 10 by construction.
  - Wrap-around does not occur.
- disparity = cnt register (post-update value).

## Timing
- Latency is 2 cycles: inputs sampled at edge N produce q_out at edge N+2. de, c0 and c1 are delayed identically to d.
- Throughput is one symbol per pxl_clk; no stalls, no handshake.
- Reset (rst=0 at an edge):
  - q_out = RST_CODE, cnt = 0.
  - Stage-1 registers clear to d=0, de=0, c=00.
  - The first two symbols after release are therefore control 00 regardless of inputs.
- Reset mid-line: the next de=1 symbol after release is encoded with cnt starting at 0.
- de 1→0 transition: the control symbol appears at N+2, and cnt is 0 from that edge.
- de 0→1 transition: the first data symbol is encoded with cnt=0 (case A).
- d changes while de=0 are ignored (no effect on cnt or q_out).

## Test plan
- Reset: hold rst=0 for 4 cycles with de=1, d=0xFF, then release → q_out=0x354 and disparity=0 during reset and for 2 cycles after release.
- Control codes: de=0, {c1,c0} stepped 00,01,10,11 → q_out 0x354, 0x0AB, 0x154, 0x2AB at 2-cycle latency; disparity stays 0.
- Zero stream: de=1, d=0x00 ×3 from cnt=0 → q_out 0x100, 0x3FF, 0x100; disparity −8, +2, −6.
- All ones: de=1, d=0xFF from cnt=0 → q_out 0x200, disparity −8.
- Line boundary: 640 cycles of d=0x00 de=1, then de=0 with c=00 → disparity returns to 0 two edges after de falls; the next de=1 with d=0x00 yields q_out 0x100.
- Random: 10k random d/de/c vectors against a reference model → bit-exact q_out; |disparity| ≤ 10 always; every 10-bit data symbol has ≤ 5 transitions.

Source files
------------

// File: rtl/tmds_channel_enc.sv
// Single-channel DVI/HDMI TMDS encoder: 8b/10b transition-minimised, DC-balanced
// symbol generation with input capture, q_m and output stages (2-cycle latency).
module tmds_channel_enc #(
  parameter logic [9:0] RST_CODE = 10'b1101010100
) (
  input  logic              pxl_clk,
  input  logic              rst,
  input  logic [7:0]        d,
  input  logic              de,
  input  logic              c0,
  input  logic              c1,
  output logic [9:0]        q_out,
  output logic signed [4:0] disparity
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // q_m[8] = 1 marks the XOR chain, 0 the XNOR chain.
  function automatic logic [8:0] transition_min(input logic [7:0] v);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] m;
    n1       = popcount8(v);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !v[0]);
    m        = '0;
    m[0]     = v[0];
    for (int i = 1; i < 8; i++) begin
      m[i] = use_xnor ? ~(m[i-1] ^ v[i]) : (m[i-1] ^ v[i]);
    end
    m[8] = ~use_xnor;
    return m;
  endfunction

  // Input capture stage
  logic [7:0]        din_q;
  logic              de_s1_q;
  logic [1:0]        ctl_s1_q;

  // Transition-minimised stage
  logic [8:0]        qm_d;
  logic [8:0]        qm_q;
  logic              de_s2_q;
  logic [1:0]        ctl_s2_q;

  // Output / disparity stage
  logic [9:0]        sym_d;
  logic [9:0]        sym_q;
  logic signed [4:0] cnt_d;
  logic signed [4:0] cnt_q;

  logic [3:0]        n1q;
  logic [4:0]        n1q_w;
  logic signed [4:0] bal;
  logic [9:0]        ctrl_sym;

  assign qm_d = transition_min(din_q);

  // bal = n1q - n0q = 2*n1q - 8, always within -8..8.
  assign n1q   = popcount8(qm_q[7:0]);
  assign n1q_w = {1'b0, n1q};
  assign bal   = $signed(n1q_w + n1q_w - 5'd8);

  always_comb begin
    ctrl_sym = CTRL_00;
    case (ctl_s2_q)
      2'b00:   ctrl_sym = CTRL_00;
      2'b01:   ctrl_sym = CTRL_01;
      2'b10:   ctrl_sym = CTRL_10;
      default: ctrl_sym = CTRL_11;
    endcase
  end

  always_comb begin
    sym_d = ctrl_sym;
    cnt_d = '0;
    if (de_s2_q) begin
      if ((cnt_q == 5'sd0) || (n1q == 4'd4)) begin
        sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
      end else if (((cnt_q > 5'sd0) && (n1q > 4'd4)) ||
                   ((cnt_q < 5'sd0) && (n1q < 4'd4))) begin
        // Inverting pulls the running disparity back toward zero.
        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q - bal + (qm_q[8] ? 5'sd2 : 5'sd0);
      end else begin
        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q + bal - (qm_q[8] ? 5'sd0 : 5'sd2);
      end
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (!rst) begin
      din_q    <= '0;
      de_s1_q  <= 1'b0;
      ctl_s1_q <= 2'b00;
      qm_q     <= '0;
      de_s2_q  <= 1'b0;
      ctl_s2_q <= 2'b00;
      sym_q    <= RST_CODE;
      cnt_q    <= '0;
    end else begin
      din_q    <= d;
      de_s1_q  <= de;
      ctl_s1_q <= {c1, c0};
      qm_q     <= qm_d;
      de_s2_q  <= de_s1_q;
      ctl_s2_q <= ctl_s1_q;
      sym_q    <= sym_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q_out     = sym_q;
  assign disparity = cnt_q;

endmodule
